pes_seq_serializer: RTL and testbench
=====================================

Name: pes_seq_serializer

Overview:
Upstream feed stage for the sequence detector (iiitb_SDM). It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on sequence_out, which drives the detector's sequence_in. A one-entry holding register lets back-to-back words stream with no idle bit between them. The bit_valid and last_bit outputs let a downstream monitor frame the stream.

Parameters:
WIDTH, 8, bits per input word (legal range 2..32)
LSB_FIRST, 0, 0 = transmit MSB first, 1 = transmit LSB first
IDLE_LEVEL, 0, value driven on sequence_out when no bit is valid

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0, released synchronously to clock by the system)
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
sequence_out  output  1  serial bit, connects to detector sequence_in
bit_valid  output  1  sequence_out carries a real data bit
last_bit  output  1  high during the final bit of each word
busy  output  1  shifter or holding register occupied

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, hold_full=0. Outputs: sequence_out=IDLE_LEVEL, bit_valid=0, last_bit=0, busy=0, in_ready=0 while reset is held. in_ready rises combinationally once reset=1.
- A partially sent word is discarded on reset. No resumption occurs.
- Handshake: a transfer occurs at a rising edge where in_valid=1 and in_ready=1. in_ready = reset && !hold_full, which is purely state-based and has no combinational dependence on in_valid. in_data is ignored when no transfer occurs.
- States:
  - IDLE: no bit on the line.
  - SHIFT: a word is being sent, and the counter cnt runs 0..WIDTH-1.
- IDLE + transfer: the word loads directly into the shift register, state goes to SHIFT, cnt=0. The first bit appears on sequence_out in the cycle after the accepting edge (latency 1).
- SHIFT, cnt<WIDTH-1: each edge advances to the next bit and increments cnt.
- SHIFT, cnt==WIDTH-1: last_bit=1 during this cycle. At the next edge:
  - if hold_full, the held word moves to the shift register, cnt=0, state stays SHIFT, hold_full=0, with no gap bit;
  - else if a transfer occurs on this same edge, that word loads directly into the shifter with no gap;
  - else the state goes to IDLE.
- SHIFT + transfer while cnt<WIDTH-1: the word is captured into the holding register and hold_full=1.
- Simultaneous edge with hold_full=1 and cnt==WIDTH-1: hold moves to the shifter and hold_full clears. in_ready was 0 that cycle, so no new capture is possible.
- Bit order:
  - LSB_FIRST=0 sends in_data[WIDTH-1] first.
  - LSB_FIRST=1 sends in_data[0] first.
- sequence_out = current shifter output bit when bit_valid=1, else IDLE_LEVEL. bit_valid=1 exactly in SHIFT.
- busy = (state==SHIFT) || hold_full.
- Throughput: one bit per clock sustained. Maximum one word per WIDTH cycles.
- The counter width is clog2(WIDTH). It never wraps past WIDTH-1 and is reloaded to 0 on each word load.

Decomposition:
- Shared package/header pes_seq_pkg holds:
  - state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - the default WIDTH;
  - the clog2 function used for the counter width.
- One natural sub-module: pes_hold_reg, a one-entry holding register with a load/unload/full flag and asynchronous active-low reset. The shifter and FSM stay in the top-level module.

Test Plan:
- Single word, WIDTH=8, LSB_FIRST=0, in_data=8'hB4 accepted at edge k -> sequence_out = 1,0,1,1,0,1,0,0 in cycles k+1..k+8; bit_valid high for exactly those 8 cycles; last_bit only in cycle k+8; then IDLE with sequence_out=0 and busy=0.
- Back-to-back: 8'hB4 then 8'h2D, with in_valid held high -> second word accepted into hold (in_ready drops to 0 until the hold empties); 16 contiguous valid bits 10110100 00101101 with no gap; last_bit high in cycles k+8 and k+16.
- Same-edge reload: present 8'hFF exactly in the cycle where last_bit=1 and hold is empty -> next bit is 1 with bit_valid still 1, and no IDLE cycle occurs.
- LSB_FIRST=1, in_data=8'h0D -> sequence_out = 1,0,1,1,0,0,0,0.
- Reset mid-word: assert reset=0 asynchronously during bit 3 of 8'hB4 with the hold full -> outputs clear immediately (bit_valid=0, busy=0, sequence_out=IDLE_LEVEL); after release, in_ready=1; no remaining bits of either word are ever emitted.
- End-to-end with the detector: serialize 8'h5B (01011011) into iiitb_SDM -> detector_out pulses at the cycles its sequence definition dictates, and at no others; compare against the golden bitstream model.

Source files
------------

// File: rtl/pes_seq_pkg.sv
// Shared types and helpers for the pes_seq serializer slice.
package pes_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pes_hold_reg.sv
// One-entry holding register that parks a word while the shifter is busy.
module pes_hold_reg
  import pes_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_r;
  logic             full_r;

  // Capture on load; unload only clears the flag, the stale data is harmless.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_r <= '0;
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= d;
      full_r <= 1'b1;
    end else if (unload) begin
      full_r <= 1'b0;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/pes_seq_serializer.sv
// Parallel-to-serial feed for the sequence detector, with a one-word skid
// so consecutive words go out without an idle bit between them.
module pes_seq_serializer
  import pes_seq_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   shift_r, shift_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               hold_load_s, hold_unload_s, hold_full_s;
  logic [WIDTH-1:0]   hold_q_s;
  logic               xfer_s, last_s, cur_bit_s;

  assign in_ready  = reset && !hold_full_s;
  assign xfer_s    = in_valid && in_ready;
  assign last_s    = (state_r == ST_SHIFT) && (cnt_r == CNT_W'(WIDTH - 1));
  assign cur_bit_s = LSB_FIRST ? shift_r[0] : shift_r[WIDTH-1];

  pes_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clock  (clock),
    .reset  (reset),
    .load   (hold_load_s),
    .unload (hold_unload_s),
    .d      (in_data),
    .q      (hold_q_s),
    .full   (hold_full_s)
  );

  // State, shifter and bit counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: at the final bit the held word wins over a fresh transfer,
  // which cannot happen anyway since in_ready is low while the hold is full.
  always_comb begin
    state_s       = state_r;
    shift_s       = shift_r;
    cnt_s         = cnt_r;
    hold_load_s   = 1'b0;
    hold_unload_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_s = ST_SHIFT;
          shift_s = in_data;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          if (hold_full_s) begin
            shift_s       = hold_q_s;
            cnt_s         = '0;
            hold_unload_s = 1'b1;
          end else if (xfer_s) begin
            shift_s = in_data;
            cnt_s   = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          shift_s     = LSB_FIRST ? {1'b0, shift_r[WIDTH-1:1]}
                                  : {shift_r[WIDTH-2:0], 1'b0};
          cnt_s       = cnt_r + CNT_W'(1);
          hold_load_s = xfer_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign bit_valid    = (state_r == ST_SHIFT);
  assign last_bit     = last_s;
  assign sequence_out = bit_valid ? cur_bit_s : IDLE_LEVEL;
  assign busy         = bit_valid || hold_full_s;

endmodule

// File: tb/tb_pes_seq_serializer.sv
// Directed bench for pes_seq_serializer: MSB-first and LSB-first instances.
module tb_pes_seq_serializer;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, sequence_out, bit_valid, last_bit, busy;
  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready, l_out, l_bv, l_last, l_busy;

  int n_pass;
  int n_total;

  pes_seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sequence_out (sequence_out),
    .bit_valid    (bit_valid),
    .last_bit     (last_bit),
    .busy         (busy)
  );

  pes_seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clock        (clock),
    .reset        (reset),
    .in_data      (l_data),
    .in_valid     (l_valid),
    .in_ready     (l_ready),
    .sequence_out (l_out),
    .bit_valid    (l_bv),
    .last_bit     (l_last),
    .busy         (l_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bv"},   bit_valid,    1'b0);
    chk({tag, "_out"},  sequence_out, 1'b0);
    chk({tag, "_busy"}, busy,         1'b0);
    chk({tag, "_last"}, last_bit,     1'b0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] ww;
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    l_data   = 8'h00;
    l_valid  = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", in_ready, 1'b0);
    chk_idle("rst");
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rel_ready", in_ready, 1'b1);
    chk_idle("rel");

    // Single word B4, MSB first
    w = 8'hB4;
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s1_bit%0d", i),  sequence_out, w[7-i]);
      chk($sformatf("s1_bv%0d", i),   bit_valid,    1'b1);
      chk($sformatf("s1_last%0d", i), last_bit,     (i == 7));
      step();
    end
    chk_idle("s1_end");

    // Back-to-back B4 then 2D through the hold register
    ww = 16'hB42D;
    in_data  = 8'hB4;
    in_valid = 1'b1;
    step();
    in_data = 8'h2D;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      chk($sformatf("b2b_bit%0d", i),   sequence_out, ww[15-i]);
      chk($sformatf("b2b_bv%0d", i),    bit_valid,    1'b1);
      chk($sformatf("b2b_last%0d", i),  last_bit,     (i == 7) || (i == 15));
      chk($sformatf("b2b_rdy%0d", i),   in_ready,     !(i >= 1 && i <= 7));
      chk($sformatf("b2b_busy%0d", i),  busy,         1'b1);
      step();
    end
    chk_idle("b2b_end");

    // Same-edge reload: 00 then FF presented during the last bit
    in_data  = 8'h00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("se_a_bit%0d", i), sequence_out, 1'b0);
      if (i == 7) begin
        chk("se_last", last_bit, 1'b1);
        chk("se_rdy",  in_ready, 1'b1);
        in_data  = 8'hFF;
        in_valid = 1'b1;
      end else begin
        chk($sformatf("se_a_last%0d", i), last_bit, 1'b0);
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("se_b_bit%0d", i),  sequence_out, 1'b1);
      chk($sformatf("se_b_bv%0d", i),   bit_valid,    1'b1);
      chk($sformatf("se_b_last%0d", i), last_bit,     (i == 7));
      step();
    end
    chk_idle("se_end");

    // LSB first on the second instance: 0D -> 1,0,1,1,0,0,0,0
    w = 8'h0D;
    l_data  = w;
    l_valid = 1'b1;
    step();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_bit%0d", i),  l_out,  w[i]);
      chk($sformatf("lsb_bv%0d", i),   l_bv,   1'b1);
      chk($sformatf("lsb_last%0d", i), l_last, (i == 7));
      step();
    end
    chk("lsb_end_bv",   l_bv,   1'b0);
    chk("lsb_end_busy", l_busy, 1'b0);
    chk("lsb_end_out",  l_out,  1'b0);

    // Reset mid-word with the hold full
    w = 8'hB4;
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_data = 8'h2D;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("mr_held", in_ready, 1'b0);
    step();
    step();
    chk("mr_bit3", sequence_out, w[4]);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_bv",   bit_valid,    1'b0);
    chk("mr_busy", busy,         1'b0);
    chk("mr_out",  sequence_out, 1'b0);
    chk("mr_rdy",  in_ready,     1'b0);
    step();
    reset = 1'b1;
    #1;
    chk("mr_rel_rdy", in_ready, 1'b1);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("mr_quiet_bv%0d", i), bit_valid, 1'b0);
      step();
    end
    chk_idle("mr_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
